// File: rtl/mem_access_scheduler.sv
// Round-robin scheduler sharing one main-memory port among NUM_REQ cache controllers,
// with a req/ack watchdog. Define WB_PRIORITY_EN to favour writeback requesters.
module mem_access_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_WAIT = 15,
  parameter int IDX_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_wr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic               mem_req,
  output logic               mem_wr,
  input  logic               mem_ack,
  output logic               timeout_err,
  output logic [IDX_W-1:0]   cur_id
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GRANT    = 2'b01,
    MEM_WAIT = 2'b10,
    RELEASE  = 2'b11
  } state_t;

  // wait_cnt_q counts MEM_WAIT cycles already completed, so the current cycle is the
  // MAX_WAIT-th one when it equals MAX_WAIT-1; the counter reads MAX_WAIT on exit.
  localparam logic [7:0] EXPIRE_CNT = 8'(MAX_WAIT - 1);
  localparam logic [7:0] CNT_MAX    = 8'hFF;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_wr_q, mem_wr_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [IDX_W-1:0]     cur_id_q, cur_id_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 wr_q, wr_d;
  logic [7:0]           wait_cnt_q, wait_cnt_d;

  logic [NUM_REQ-1:0]   cand;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     scan_idx;
  logic                 expire;

`ifdef WB_PRIORITY_EN
  assign cand = (|(req & req_wr)) ? (req & req_wr) : req;
`else
  assign cand = req;
`endif

  // First candidate after rr_ptr, wrapping; rr_ptr itself is scanned last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = rr_ptr_q + IDX_W'(k);
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign expire = (wait_cnt_q == EXPIRE_CNT);

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    done_d        = '0;
    mem_req_d     = mem_req_q;
    mem_wr_d      = mem_wr_q;
    timeout_err_d = timeout_err_q;
    cur_id_d      = cur_id_q;
    rr_ptr_d      = rr_ptr_q;
    wr_d          = wr_q;
    wait_cnt_d    = wait_cnt_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d    = NUM_REQ'(1) << win_idx;
          cur_id_d = win_idx;
          wr_d     = req_wr[win_idx];
          state_d  = GRANT;
        end
      end
      GRANT: begin
        mem_req_d  = 1'b1;
        mem_wr_d   = wr_q;
        wait_cnt_d = '0;
        state_d    = MEM_WAIT;
      end
      MEM_WAIT: begin
        wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 8'd1;
        if (mem_ack || expire) begin
          mem_req_d        = 1'b0;
          mem_wr_d         = 1'b0;
          done_d[cur_id_q] = 1'b1;
          state_d          = RELEASE;
          // An ack arriving on the expiry cycle wins over the watchdog.
          if (!mem_ack) begin
            timeout_err_d = 1'b1;
          end
        end
      end
      RELEASE: begin
        if (!req[cur_id_q]) begin
          gnt_d    = '0;
          rr_ptr_d = cur_id_q;
          cur_id_d = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      done_q        <= '0;
      mem_req_q     <= 1'b0;
      mem_wr_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      cur_id_q      <= '0;
      rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
      wr_q          <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      mem_req_q     <= mem_req_d;
      mem_wr_q      <= mem_wr_d;
      timeout_err_q <= timeout_err_d;
      cur_id_q      <= cur_id_d;
      rr_ptr_q      <= rr_ptr_d;
      wr_q          <= wr_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign mem_req     = mem_req_q;
  assign mem_wr      = mem_wr_q;
  assign timeout_err = timeout_err_q;
  assign cur_id      = cur_id_q;

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Self-checking bench for mem_access_scheduler: directed scenarios plus randomized
// transactions compared against a transaction-level round-robin model.
module tb_mem_access_scheduler;

  localparam int MAX_WAIT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] req_wr = 4'b0000;
  logic       mem_ack = 1'b0;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       mem_req;
  logic       mem_wr;
  logic       timeout_err;
  logic [1:0] cur_id;

  int checks = 0;
  int failures = 0;
  int rr_m = 3;
  bit to_m = 1'b0;

  mem_access_scheduler #(.NUM_REQ(4), .MAX_WAIT(MAX_WAIT), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .gnt(gnt), .done(done),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_ack(mem_ack),
    .timeout_err(timeout_err), .cur_id(cur_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: next requester after the last served one, writebacks first if enabled.
  function automatic int model_pick(input logic [3:0] r, input logic [3:0] w, input int rr);
    logic [3:0] c;
    c = r;
`ifdef WB_PRIORITY_EN
    if ((r & w) != 4'b0000) c = r & w;
`endif
    for (int k = 1; k <= 4; k++) begin
      if (c[(rr + k) % 4]) return (rr + k) % 4;
    end
    return -1;
  endfunction

  function automatic int model_hi(input int lat);
    return (lat < 0 || lat >= MAX_WAIT) ? MAX_WAIT : lat + 1;
  endfunction

  task automatic apply_reset;
    req = 4'b0000; req_wr = 4'b0000; mem_ack = 1'b0;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    rr_m = 3; to_m = 1'b0;
  endtask

  // Runs one transaction from IDLE and returns observations; lat<0 means memory never acks.
  task automatic run_txn(input logic [3:0] r, input logic [3:0] w, input int lat,
                         input bit drop_early, input bit stray_ack,
                         output logic [3:0] g_obs, output logic [1:0] id_obs,
                         output logic mw_obs, output int hi_cycles,
                         output logic [3:0] done_obs, output logic [3:0] done_next,
                         output logic [3:0] gnt_hold, output logic [3:0] gnt_final,
                         output logic [1:0] id_final);
    req = r; req_wr = w;
    tick;
    g_obs = gnt; id_obs = cur_id;
    req_wr = ~w;
    if (stray_ack) mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    mw_obs = mem_wr;
    if (drop_early) req = 4'b0000;
    hi_cycles = 0;
    for (int n = 0; n < 300; n++) begin
      if (!mem_req) break;
      hi_cycles++;
      mem_ack = (n == lat);
      tick;
    end
    mem_ack = 1'b0;
    done_obs = done;
    tick;
    done_next = done;
    gnt_hold = gnt;
    req = 4'b0000;
    tick;
    gnt_final = gnt;
    id_final = cur_id;
  endtask

  task automatic test_reset;
    rst = 1'b0; req = 4'b1111; req_wr = 4'b1111;
    tick; tick; tick;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++;
    if (done !== 4'b0000) begin failures++; $display("FAIL reset_done got=%b exp=0000", done); end
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++;
    if (mem_wr !== 1'b0) begin failures++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
    checks++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout_err); end
    checks++;
    if (cur_id !== 2'd0) begin failures++; $display("FAIL reset_cur_id got=%0d exp=0", cur_id); end
    checks++;
    req = 4'b0000; req_wr = 4'b0000;
    rst = 1'b1;
    rr_m = 3; to_m = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_read;
    logic [3:0] g, d0, d1, gh, gf; logic [1:0] id, idf; logic mw; int hi;
    run_txn(4'b0100, 4'b0000, 3, 1'b0, 1'b0, g, id, mw, hi, d0, d1, gh, gf, idf);
    $display("single_read gnt=%b mem_wr=%b hi=%0d done=%b", g, mw, hi, d0);
    if (g !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", g); end
    checks++;
    if (id !== 2'd2) begin failures++; $display("FAIL single_cur_id got=%0d exp=2", id); end
    checks++;
    if (mw !== 1'b0) begin failures++; $display("FAIL single_mem_wr got=%b exp=0", mw); end
    checks++;
    if (hi !== 4) begin failures++; $display("FAIL single_mem_req_cycles got=%0d exp=4", hi); end
    checks++;
    if (d0 !== 4'b0100) begin failures++; $display("FAIL single_done got=%b exp=0100", d0); end
    checks++;
    if (d1 !== 4'b0000) begin failures++; $display("FAIL single_done_pulse got=%b exp=0000", d1); end
    checks++;
    if (gh !== 4'b0100) begin failures++; $display("FAIL single_gnt_hold got=%b exp=0100", gh); end
    checks++;
    if (gf !== 4'b0000 || idf !== 2'd0) begin
      failures++; $display("FAIL single_release got gnt=%b id=%0d exp gnt=0000 id=0", gf, idf);
    end
    checks++;
    rr_m = 2;
  endtask

  task automatic test_fairness;
    logic [3:0] g, d0, d1, gh, gf; logic [1:0] id, idf; logic mw; int hi;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    apply_reset;
    for (int t = 0; t < 5; t++) begin
      run_txn(4'b1111, 4'b0000, 0, 1'b0, 1'b0, g, id, mw, hi, d0, d1, gh, gf, idf);
      $display("fairness grant %0d gnt=%b cur_id=%0d", t, g, id);
      if (g !== (4'b0001 << exp_order[t]) || id !== 2'(exp_order[t])) begin
        failures++;
        $display("FAIL fairness_%0d got gnt=%b id=%0d exp id=%0d", t, g, id, exp_order[t]);
      end
      checks++;
      if (hi !== 1) begin failures++; $display("FAIL fairness_hi_%0d got=%0d exp=1", t, hi); end
      checks++;
    end
    rr_m = 0;
  endtask

  task automatic test_timeout;
    logic [3:0] g, d0, d1, gh, gf; logic [1:0] id, idf; logic mw; int hi;
    run_txn(4'b1000, 4'b1000, -1, 1'b0, 1'b0, g, id, mw, hi, d0, d1, gh, gf, idf);
    $display("timeout gnt=%b hi=%0d done=%b err=%b", g, hi, d0, timeout_err);
    if (hi !== MAX_WAIT) begin failures++; $display("FAIL timeout_hi got=%0d exp=%0d", hi, MAX_WAIT); end
    checks++;
    if (mw !== 1'b1) begin failures++; $display("FAIL timeout_mem_wr got=%b exp=1", mw); end
    checks++;
    if (d0 !== 4'b1000) begin failures++; $display("FAIL timeout_done got=%b exp=1000", d0); end
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", timeout_err); end
    checks++;
    run_txn(4'b0010, 4'b0000, 2, 1'b0, 1'b0, g, id, mw, hi, d0, d1, gh, gf, idf);
    $display("after_timeout gnt=%b hi=%0d err=%b", g, hi, timeout_err);
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", timeout_err); end
    checks++;
    if (hi !== 3) begin failures++; $display("FAIL after_timeout_hi got=%0d exp=3", hi); end
    checks++;
    rr_m = 1; to_m = 1'b1;
  endtask

  task automatic test_reset_mid;
    req = 4'b0100; req_wr = 4'b0100;
    tick; tick; tick;
    #2 rst = 1'b0;
    #1;
    $display("reset_mid gnt=%b mem_req=%b mem_wr=%b err=%b", gnt, mem_req, mem_wr, timeout_err);
    if (gnt !== 4'b0000 || mem_req !== 1'b0 || mem_wr !== 1'b0) begin
      failures++; $display("FAIL reset_mid_outputs got gnt=%b mem_req=%b mem_wr=%b exp all 0", gnt, mem_req, mem_wr);
    end
    checks++;
    if (done !== 4'b0000 || cur_id !== 2'd0 || timeout_err !== 1'b0) begin
      failures++; $display("FAIL reset_mid_status got done=%b id=%0d err=%b exp 0", done, cur_id, timeout_err);
    end
    checks++;
    req = 4'b0001; req_wr = 4'b0000;
    tick;
    rst = 1'b1;
    tick;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL reset_mid_regrant got=%b exp=0001", gnt); end
    checks++;
    tick;
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    if (done !== 4'b0001) begin failures++; $display("FAIL reset_mid_done got=%b exp=0001", done); end
    checks++;
    req = 4'b0000;
    tick;
    rr_m = 0; to_m = 1'b0;
  endtask

  task automatic test_ack_at_expiry;
    logic [3:0] g, d0, d1, gh, gf; logic [1:0] id, idf; logic mw; int hi;
    run_txn(4'b0010, 4'b0000, MAX_WAIT - 1, 1'b0, 1'b1, g, id, mw, hi, d0, d1, gh, gf, idf);
    $display("ack_at_expiry gnt=%b hi=%0d err=%b", g, hi, timeout_err);
    if (hi !== MAX_WAIT) begin failures++; $display("FAIL expiry_ack_hi got=%0d exp=%0d", hi, MAX_WAIT); end
    checks++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL expiry_ack_err got=%b exp=0", timeout_err); end
    checks++;
    if (d0 !== 4'b0010) begin failures++; $display("FAIL expiry_ack_done got=%b exp=0010", d0); end
    checks++;
    rr_m = 1;
  endtask

  task automatic test_wb_priority;
    logic [3:0] g, d0, d1, gh, gf; logic [1:0] id, idf; logic mw; int hi, win;
    apply_reset;
    win = model_pick(4'b0011, 4'b0010, rr_m);
    run_txn(4'b0011, 4'b0010, 1, 1'b0, 1'b0, g, id, mw, hi, d0, d1, gh, gf, idf);
    $display("wb_priority gnt=%b mem_wr=%b", g, mw);
`ifdef WB_PRIORITY_EN
    if (g !== 4'b0010) begin failures++; $display("FAIL wb_priority_gnt got=%b exp=0010", g); end
`else
    if (g !== 4'b0001) begin failures++; $display("FAIL wb_priority_gnt got=%b exp=0001", g); end
`endif
    checks++;
    if (mw !== (win == 1)) begin failures++; $display("FAIL wb_priority_mem_wr got=%b exp=%0d", mw, win == 1); end
    checks++;
    rr_m = win;
  endtask

  task automatic test_random;
    logic [3:0] g, d0, d1, gh, gf, r, w, eg; logic [1:0] id, idf; logic mw;
    int hi, win, lat; bit drop, stray, timed;
    for (int t = 0; t < 40; t++) begin
      r = 4'($urandom_range(1, 15));
      w = 4'($urandom());
      lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 16));
      drop = ($urandom_range(0, 3) == 0);
      stray = ($urandom_range(0, 3) == 0);
      win = model_pick(r, w, rr_m);
      eg = 4'b0001 << win;
      timed = (lat < 0 || lat >= MAX_WAIT);
      run_txn(r, w, lat, drop, stray, g, id, mw, hi, d0, d1, gh, gf, idf);
      rr_m = win;
      to_m = to_m | timed;
      $display("txn %0d req=%b wr=%b lat=%0d drop=%0d gnt=%b mem_wr=%b hi=%0d err=%b",
               t, r, w, lat, drop, g, mw, hi, timeout_err);
      if (g !== eg || id !== 2'(win)) begin
        failures++; $display("FAIL rand_gnt_%0d got gnt=%b id=%0d exp gnt=%b", t, g, id, eg);
      end
      checks++;
      if (mw !== w[win]) begin failures++; $display("FAIL rand_mem_wr_%0d got=%b exp=%b", t, mw, w[win]); end
      checks++;
      if (hi !== model_hi(lat)) begin
        failures++; $display("FAIL rand_hi_%0d got=%0d exp=%0d", t, hi, model_hi(lat));
      end
      checks++;
      if (d0 !== eg || d1 !== 4'b0000) begin
        failures++; $display("FAIL rand_done_%0d got=%b then %b exp=%b then 0000", t, d0, d1, eg);
      end
      checks++;
      if (gh !== (drop ? 4'b0000 : eg) || gf !== 4'b0000 || idf !== 2'd0) begin
        failures++; $display("FAIL rand_release_%0d got hold=%b final=%b id=%0d", t, gh, gf, idf);
      end
      checks++;
      if (timeout_err !== to_m) begin
        failures++; $display("FAIL rand_timeout_%0d got=%b exp=%b", t, timeout_err, to_m);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_fairness;
    test_timeout;
    test_reset_mid;
    test_ack_at_expiry;
    test_wb_priority;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
